video_timing_gen: RTL

- Parametrised successor to the fixed-mode VGA sync generator: produces hsync, vsync, data-enable and beam coordinates for any raster geometry.
- Adds a pixel clock-enable so the system clock can run faster than the pixel rate.
- Adds independent H/V sync polarity, a run/hold control, line/frame start strobes and a frame counter.
- Sits between the system clock domain and the video DAC/pixel pipeline; feeds the framebuffer fetch and character-generator blocks.

---
 rtl/video_timing_gen_if.sv | 39 +++
 rtl/video_timing_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: run/pix_ce control in, sync/de/coordinates/strobes out.
// The fetch_* look-ahead signals exist only when VTG_PREFETCH_EN is defined.
interface video_timing_gen_if #(
   parameter int HPOS_W  = 10,
   parameter int VPOS_W  = 10,
   parameter int FRAME_W = 8
);
   logic               pix_ce;
   logic               run;
   logic               hsync;
   logic               vsync;
   logic               de;
   logic [HPOS_W-1:0]  hpos;
   logic [VPOS_W-1:0]  vpos;
   logic               line_start;
   logic               frame_start;
   logic [FRAME_W-1:0] frame_cnt;
`ifdef VTG_PREFETCH_EN
   logic [HPOS_W-1:0]  fetch_x;
   logic [VPOS_W-1:0]  fetch_y;
   logic               fetch_de;
`endif

   modport master (
      input  pix_ce, run,
      output hsync, vsync, de, hpos, vpos, line_start, frame_start, frame_cnt
`ifdef VTG_PREFETCH_EN
      , output fetch_x, fetch_y, fetch_de
`endif
   );

   modport slave (
      output pix_ce, run,
      input  hsync, vsync, de, hpos, vpos, line_start, frame_start, frame_cnt
`ifdef VTG_PREFETCH_EN
      , input fetch_x, fetch_y, fetch_de
`endif
   );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster generator (hsync/vsync/de/coords, strobes, frame count); VTG_PREFETCH_EN adds one-tick-ahead fetch coords.
// Outputs registered, updated the clk after each pix_ce tick; no backpressure, run=0 parks at the idle position.
module video_timing_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter bit H_SYNC_NEG = 1'b1,
   parameter bit V_SYNC_NEG = 1'b1,
   parameter int HPOS_W     = 10,
   parameter int VPOS_W     = 10,
   parameter int FRAME_W    = 8
) (
   input logic                clk,
   input logic                reset,
   video_timing_gen_if.master vif
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_BEG  = H_DISPLAY + H_FRONT;
   localparam int HS_END  = HS_BEG + H_SYNC;
   localparam int VS_BEG  = V_DISPLAY + V_FRONT;
   localparam int VS_END  = VS_BEG + V_SYNC;

   localparam logic [HPOS_W-1:0] H_LAST = HPOS_W'(H_TOTAL - 1);
   localparam logic [VPOS_W-1:0] V_LAST = VPOS_W'(V_TOTAL - 1);

   if ((H_TOTAL - 1) >= (1 << HPOS_W)) begin : g_hpos_chk
      $error("video_timing_gen: HPOS_W too narrow for H_TOTAL-1");
   end
   if ((V_TOTAL - 1) >= (1 << VPOS_W)) begin : g_vpos_chk
      $error("video_timing_gen: VPOS_W too narrow for V_TOTAL-1");
   end

   typedef struct packed {
      logic [HPOS_W-1:0] h;
      logic [VPOS_W-1:0] v;
   } pos_t;

   localparam pos_t IDLE_POS = '{h: H_LAST, v: V_LAST};

   function automatic pos_t advance(input pos_t p);
      pos_t n;
      n.h = (p.h == H_LAST) ? '0 : p.h + HPOS_W'(1);
      n.v = p.v;
      if (p.h == H_LAST) begin
         n.v = (p.v == V_LAST) ? '0 : p.v + VPOS_W'(1);
      end
      return n;
   endfunction

   // Sync polarity is applied by XOR with the active-low flag.
   function automatic logic hs_of(input pos_t p);
      return ((int'(p.h) >= HS_BEG) && (int'(p.h) < HS_END)) ^ H_SYNC_NEG;
   endfunction

   function automatic logic vs_of(input pos_t p);
      return ((int'(p.v) >= VS_BEG) && (int'(p.v) < VS_END)) ^ V_SYNC_NEG;
   endfunction

   function automatic logic de_of(input pos_t p);
      return (int'(p.h) < H_DISPLAY) && (int'(p.v) < V_DISPLAY);
   endfunction

   pos_t               pos_q;
   pos_t               pos_nxt;
   logic               hsync_q;
   logic               vsync_q;
   logic               de_q;
   logic               line_start_q;
   logic               frame_start_q;
   logic [FRAME_W-1:0] frame_cnt_q;

   assign pos_nxt = advance(pos_q);

   // Sync/de are derived from the same position written to pos_q, so they never skew.
   always_ff @(posedge clk) begin
      if (reset || !vif.run) begin
         pos_q         <= IDLE_POS;
         hsync_q       <= hs_of(IDLE_POS);
         vsync_q       <= vs_of(IDLE_POS);
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         if (reset) begin
            frame_cnt_q <= '0;
         end
      end else if (vif.pix_ce) begin
         pos_q         <= pos_nxt;
         hsync_q       <= hs_of(pos_nxt);
         vsync_q       <= vs_of(pos_nxt);
         de_q          <= de_of(pos_nxt);
         line_start_q  <= (pos_nxt.h == '0);
         frame_start_q <= (pos_nxt == '0);
         if (pos_nxt == '0) begin
            frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
         end
      end else begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end
   end

   assign vif.hpos        = pos_q.h;
   assign vif.vpos        = pos_q.v;
   assign vif.hsync       = hsync_q;
   assign vif.vsync       = vsync_q;
   assign vif.de          = de_q;
   assign vif.line_start  = line_start_q;
   assign vif.frame_start = frame_start_q;
   assign vif.frame_cnt   = frame_cnt_q;

`ifdef VTG_PREFETCH_EN
   pos_t fetch_q;
   logic fetch_de_q;

   // While running and parked between ticks the look-ahead still tracks pos_q, so it lifts out of idle at once.
   always_ff @(posedge clk) begin
      if (reset || !vif.run) begin
         fetch_q    <= '0;
         fetch_de_q <= 1'b0;
      end else if (vif.pix_ce) begin
         fetch_q    <= advance(pos_nxt);
         fetch_de_q <= de_of(advance(pos_nxt));
      end else begin
         fetch_q    <= pos_nxt;
         fetch_de_q <= de_of(pos_nxt);
      end
   end

   assign vif.fetch_x  = fetch_q.h;
   assign vif.fetch_y  = fetch_q.v;
   assign vif.fetch_de = fetch_de_q;
`endif
endmodule
